// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared tile-map geometry, arbiter state encoding and blanking helper
package vram_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned MAP_W    = 80;
  localparam int unsigned MAP_H    = 60;
  localparam int unsigned MAP_SIZE = MAP_W * MAP_H;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } vram_state_e;

  function automatic logic in_blanking(input logic [9:0] hpos, input logic [9:0] vpos);
    return (hpos >= 10'(H_ACTIVE)) || (vpos >= 10'(V_ACTIVE));
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - game-logic write queue; head is read combinationally so a pop takes the old head
module vram_wr_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port tile-map RAM owner: video fetch > map clear > queued writes
module vram_arbiter #(
  parameter int unsigned ADDR_W        = 13,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned MAP_SIZE      = 4800,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter bit          WR_BLANK_ONLY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic [3:0]        fifo_level,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  import vram_pkg::*;

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);

  vram_state_e       state;
  vram_state_e       state_d;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] clr_addr_d;
  logic [DATA_W-1:0] clr_val;
  logic [DATA_W-1:0] clr_val_d;
  logic              fetch_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [LVL_W-1:0]  level;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              drain_ok;
  logic              clr_last;

  assign {head_addr, head_data} = fifo_head;
  assign wr_ready   = reset & ~fifo_full;
  assign fifo_push  = wr_valid & wr_ready;
  assign fifo_level = 4'(level);
  assign drain_ok   = !WR_BLANK_ONLY || in_blanking(hpos, vpos);
  assign clr_last   = (clr_addr == ADDR_W'(MAP_SIZE - 1));
  assign clr_busy   = (state == CLEAR);
  assign vid_rvalid = fetch_q;
  assign vid_rdata  = fetch_q ? ram_rdata : '0;

  vram_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data ({wr_addr, wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The RAM port is driven straight from this decision so a fetch costs exactly one cycle.
  always_comb begin
    state_d    = state;
    clr_addr_d = clr_addr;
    clr_val_d  = clr_val;
    fifo_pop   = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (reset) begin
      if (vid_req) begin
        ram_en   = 1'b1;
        ram_addr = vid_addr;
      end else if (state == CLEAR) begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = clr_addr;
        ram_wdata  = clr_val;
        clr_addr_d = clr_addr + ADDR_W'(1);
        if (clr_last) begin
          state_d = IDLE;
        end
      end else if (!fifo_empty && drain_ok) begin
        fifo_pop  = 1'b1;
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = head_addr;
        ram_wdata = head_data;
      end
      // A start coinciding with a pop still lets the pop through this cycle.
      if (state == IDLE && clr_start) begin
        state_d    = CLEAR;
        clr_addr_d = '0;
        clr_val_d  = clr_value;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      clr_addr <= '0;
      clr_val  <= '0;
      fetch_q  <= 1'b0;
    end else begin
      state    <= state_d;
      clr_addr <= clr_addr_d;
      clr_val  <= clr_val_d;
      fetch_q  <= vid_req;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with a queue-based reference model
module tb_vram_arbiter;

  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 8;
  localparam int MAP_SIZE = 4800;
  localparam int DEPTH    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [9:0]        hpos, vpos;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_start;
  logic [DATA_W-1:0] clr_value;
  logic              clr_busy;
  logic [3:0]        fifo_level;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always #20 clk = ~clk;

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAP_SIZE(MAP_SIZE),
    .FIFO_DEPTH(DEPTH), .WR_BLANK_ONLY(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy), .fifo_level(fifo_level),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Tile RAM: read-first, one-cycle read latency, plus bench-side preload port.
  logic [7:0]  mem [0:8191];
  logic        pre_fill, pre_we;
  logic [12:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clk) begin
    if (pre_fill) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'hFF;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Reference model: pending writes as a queue, clear as a counter, fetch as a one-deep pipe.
  typedef struct packed {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         wlog[$];
  logic        m_clr;
  logic [12:0] m_ca;
  logic [7:0]  m_cv;
  logic        m_vpend;
  logic [7:0]  m_vdata;
  int          port_err = 0;
  int          rv_err = 0;
  int          lvl_err = 0;
  int          rv_count = 0;

  always @(negedge clk) begin : model
    logic ok, blank, g_clr, g_q, was_clr;
    int   old_sz;
    if (!reset) begin
      exp_q.delete();
      m_clr   = 1'b0;
      m_ca    = '0;
      m_cv    = '0;
      m_vpend = 1'b0;
      m_vdata = '0;
    end else begin
      if (vid_rvalid !== m_vpend || (m_vpend && vid_rdata !== m_vdata)) rv_err++;
      if (vid_rvalid === 1'b1) rv_count++;
      old_sz = exp_q.size();
      if (fifo_level !== 4'(old_sz) || wr_ready !== (old_sz < DEPTH) || clr_busy !== m_clr)
        lvl_err++;
      blank = (hpos >= 10'd640) || (vpos >= 10'd480);
      g_clr = 1'b0;
      g_q   = 1'b0;
      if (vid_req) begin
        ok = (ram_en === 1'b1) && (ram_we === 1'b0) && (ram_addr === vid_addr);
      end else if (m_clr) begin
        g_clr = 1'b1;
        ok = (ram_en === 1'b1) && (ram_we === 1'b1) && (ram_addr === m_ca) && (ram_wdata === m_cv);
      end else if (old_sz > 0 && blank) begin
        g_q = 1'b1;
        ok = (ram_en === 1'b1) && (ram_we === 1'b1) && (ram_addr === exp_q[0].a) &&
             (ram_wdata === exp_q[0].d);
      end else begin
        ok = (ram_en === 1'b0);
      end
      if (!ok) port_err++;
      if (ram_en === 1'b1 && ram_we === 1'b1) wlog.push_back({ram_addr, ram_wdata});
      m_vpend = vid_req;
      m_vdata = mem[vid_addr];
      was_clr = m_clr;
      if (g_clr) begin
        if (m_ca == 13'(MAP_SIZE - 1)) m_clr = 1'b0;
        m_ca = m_ca + 13'd1;
      end
      if (g_q) void'(exp_q.pop_front());
      if (wr_valid && old_sz < DEPTH) exp_q.push_back({wr_addr, wr_data});
      if (!was_clr && clr_start) begin
        m_clr = 1'b1;
        m_ca  = '0;
        m_cv  = clr_value;
      end
    end
  end

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       drain;
  } bvec_t;

  bvec_t bv [9];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, bad, last_n, drop_n, nz, rv0;

    bv[0] = '{10'd0,   10'd0,   1'b0};
    bv[1] = '{10'd639, 10'd0,   1'b0};
    bv[2] = '{10'd640, 10'd0,   1'b1};
    bv[3] = '{10'd799, 10'd0,   1'b1};
    bv[4] = '{10'd100, 10'd479, 1'b0};
    bv[5] = '{10'd100, 10'd480, 1'b1};
    bv[6] = '{10'd0,   10'd524, 1'b1};
    bv[7] = '{10'd639, 10'd479, 1'b0};
    bv[8] = '{10'd640, 10'd480, 1'b1};

    reset = 1'b0; hpos = '0; vpos = '0; vid_req = 1'b0; vid_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_start = 1'b0; clr_value = '0;
    pre_fill = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) step();
    pre_fill = 1'b0;

    // Reset state: everything low even with a request pending.
    vid_req = 1'b1; settle();
    check("rst_ram_en", ram_en, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rvalid", vid_rvalid, 0);
    check("rst_clr_busy", clr_busy, 0);
    vid_req = 1'b0;
    step();
    reset = 1'b1; settle();
    check("rel_wr_ready", wr_ready, 1);
    check("rel_level", fifo_level, 0);
    check("rel_ram_en", ram_en, 0);

    // Blanking decision table: one queued write, drained only when blanking.
    for (int i = 0; i < 9; i++) begin
      hpos = '0; vpos = '0;
      wr_valid = 1'b1; wr_addr = 13'(300 + i); wr_data = 8'(8'h10 + i);
      step();
      wr_valid = 1'b0;
      hpos = bv[i].h; vpos = bv[i].v; settle();
      check($sformatf("blank_we[%0d]", i), ram_we, bv[i].drain);
      check($sformatf("blank_lvl[%0d]", i), fifo_level, 1);
      if (!bv[i].drain) hpos = 10'd640;
      step();
      hpos = '0; vpos = '0; settle();
      check($sformatf("blank_empty[%0d]", i), fifo_level, 0);
      check($sformatf("blank_mem[%0d]", i), mem[300 + i], 32'(8'h10 + i));
    end

    // Back-to-back fetches across the active line.
    pre_we = 1'b1; pre_addr = 13'd5; pre_data = 8'h2A; step();
    pre_we = 1'b0;
    settle();
    check("fetch_idle_rvalid", vid_rvalid, 0);
    rv0 = rv_count; bad = 0; vid_addr = 13'd5; vpos = '0;
    for (int h = 0; h < 640; h++) begin
      hpos = 10'(h); vid_req = 1'b1; settle();
      if (h > 0 && (vid_rvalid !== 1'b1 || vid_rdata !== 8'h2A)) bad++;
      step();
    end
    vid_req = 1'b0; settle();
    check("fetch_last_data", vid_rdata, 8'h2A);
    check("fetch_gaps", bad, 0);
    step(); step();
    check("fetch_count", rv_count - rv0, 640);

    // Writes pushed in active video wait for blanking, then drain in order.
    wlog.delete(); hpos = 10'd100; vpos = '0;
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1; wr_addr = 13'(400 + k); wr_data = 8'(8'hA0 + k);
      step();
    end
    wr_valid = 1'b0; settle();
    check("hold_level", fifo_level, 3);
    for (int h = 101; h < 640; h++) begin
      hpos = 10'(h); step();
    end
    check("hold_no_we", wlog.size(), 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      hpos = 10'(640 + k); settle();
      if (fifo_level !== 4'(3 - k) || ram_we !== 1'b1) bad++;
      step();
    end
    settle();
    check("drain_steps", bad, 0);
    check("drain_level", fifo_level, 0);
    bad = 0;
    for (int k = 0; k < 3; k++)
      if (k >= wlog.size() || wlog[k] != {13'(400 + k), 8'(8'hA0 + k)}) bad++;
    check("drain_order", bad, 0);

    // Overfill: ninth write is held until a slot frees, nothing lost.
    wlog.delete(); hpos = 10'd100; bad = 0;
    for (int k = 0; k < 8; k++) begin
      wr_valid = 1'b1; wr_addr = 13'(500 + k); wr_data = 8'(8'h30 + k); settle();
      if (wr_ready !== 1'b1) bad++;
      step();
    end
    wr_addr = 13'd508; wr_data = 8'h38; settle();
    check("full_pre_ready", bad, 0);
    check("full_ready", wr_ready, 0);
    check("full_level", fifo_level, 8);
    step(); settle();
    check("full_held", fifo_level, 8);
    hpos = 10'd640; n = 0;
    while (wr_ready !== 1'b1 && n < 10) begin
      step(); settle(); n++;
    end
    check("full_accept", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    repeat (12) step();
    check("full_drain_cnt", wlog.size(), 9);
    bad = 0;
    for (int k = 0; k < 9; k++)
      if (k >= wlog.size() || wlog[k] != {13'(500 + k), 8'(8'h30 + k)}) bad++;
    check("full_order", bad, 0);

    // Reset in the middle of a clear abandons it.
    hpos = 10'd100;
    clr_value = 8'h77; clr_start = 1'b1; step();
    clr_start = 1'b0; settle();
    check("clr_busy_on", clr_busy, 1);
    check("clr_first_addr", ram_addr, 0);
    repeat (100) step();
    settle();
    check("clr_addr100", ram_addr, 100);
    reset = 1'b0; settle();
    check("midclr_rst_en", ram_en, 0);
    step();
    reset = 1'b1; settle();
    check("midclr_busy", clr_busy, 0);
    check("midclr_level", fifo_level, 0);
    check("midclr_en", ram_en, 0);
    check("midclr_ready", wr_ready, 1);

    // Full clear with video every other cycle and a write queued during the clear.
    wlog.delete();
    clr_value = 8'h00; clr_start = 1'b1; step();
    clr_start = 1'b0;
    n = 0; last_n = -1; drop_n = -1;
    while (n < 12000) begin
      vid_req  = n[0];
      vid_addr = 13'($urandom_range(MAP_SIZE - 1));
      wr_valid = (n == 3);
      wr_addr  = 13'd10; wr_data = 8'h55;
      settle();
      if (n == 0) check("clr_restart_addr", ram_addr, 0);
      if (!clr_busy) begin
        drop_n = n;
        break;
      end
      if (ram_en && ram_we && ram_addr == 13'(MAP_SIZE - 1)) last_n = n;
      step();
      n++;
    end
    vid_req = 1'b0; wr_valid = 1'b0;
    check("clr_drop_after_last", drop_n - last_n, 1);
    check("clr_write_cnt", wlog.size(), MAP_SIZE);
    nz = 0;
    for (int a = 0; a < MAP_SIZE; a++) if (mem[a] !== 8'h00) nz++;
    check("clr_all_zero", nz, 0);
    check("clr_queue_kept", fifo_level, 1);
    hpos = 10'd640;
    repeat (3) step();
    check("clr_overwrite", mem[10], 8'h55);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      hpos     = 10'($urandom_range(799));
      vpos     = ($urandom_range(3) == 0) ? 10'($urandom_range(524, 480)) : 10'($urandom_range(479));
      vid_req  = 1'($urandom_range(1));
      vid_addr = 13'($urandom_range(MAP_SIZE - 1));
      wr_valid = 1'($urandom_range(1));
      wr_addr  = 13'($urandom_range(MAP_SIZE - 1));
      wr_data  = 8'($urandom);
      step();
    end
    vid_req = 1'b0; wr_valid = 1'b0;
    repeat (2) step();

    check("model_port", port_err, 0);
    check("model_fetch", rv_err, 0);
    check("model_level", lvl_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
